// File: rtl/imem_arb_pkg.sv
// Shared types and default widths for the instruction-memory port arbiter
// and the fetch stage that sits in front of it.
package imem_arb_pkg;

   localparam int IMEM_ADDR_W       = 9;
   localparam int IMEM_DATA_W       = 34;
   localparam int IMEM_ADDR_STEP    = 4;
   localparam int IMEM_FLUSH_CYCLES = 3;

   typedef enum logic [1:0] {
      FLUSH,
      RUN,
      LOAD
   } arb_state_t;

   // The flush counter only has to hold FLUSH_CYCLES-1.
   function automatic int flush_cnt_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/imem_load_addr_gen.sv
// Loader write-address generator: address counter, accepted-word count and
// a sticky full flag once the top slot of the address space has been written.
module imem_load_addr_gen
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W    = IMEM_ADDR_W,
   parameter int ADDR_STEP = IMEM_ADDR_STEP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              advance,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W-1:0] count,
   output logic              full,
   output logic              at_last
);

   localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'((2 ** ADDR_W) - ADDR_STEP);

   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] count_reg;
   logic              full_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         addr_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
      end else if (clear) begin
         addr_reg  <= '0;
         count_reg <= '0;
         full_reg  <= 1'b0;
      end else if (advance) begin
         addr_reg  <= addr_reg + STEP;
         count_reg <= count_reg + ADDR_W'(1);
         if (addr_reg == LAST_ADDR) begin
            full_reg <= 1'b1;
         end
      end
   end

   assign addr    = addr_reg;
   assign count   = count_reg;
   assign full    = full_reg;
   assign at_last = (addr_reg == LAST_ADDR);

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares the single IMEM port between fetch reads and the program loader,
// holding the CPU during a load and for a flush window afterwards.
module imem_port_arbiter
   import imem_arb_pkg::*;
#(
   parameter int ADDR_W       = IMEM_ADDR_W,
   parameter int DATA_W       = IMEM_DATA_W,
   parameter int ADDR_STEP    = IMEM_ADDR_STEP,
   parameter int FLUSH_CYCLES = IMEM_FLUSH_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_en_i,
   input  logic [ADDR_W-1:0] fetch_addr_i,
   output logic [DATA_W-1:0] fetch_data_o,
   output logic              fetch_valid_o,
   output logic              cpu_hold_o,
   input  logic              ld_start_i,
   input  logic              ld_valid_i,
   input  logic [DATA_W-1:0] ld_data_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              ld_busy_o,
   output logic [ADDR_W-1:0] ld_count_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic              mem_wren_o,
   input  logic [DATA_W-1:0] mem_q_i
);

   localparam int                 FLUSH_W    = flush_cnt_width(FLUSH_CYCLES);
   localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);

   arb_state_t         state_reg;
   logic [FLUSH_W-1:0] flush_cnt_reg;
   logic               fetch_pending_reg;

   logic              in_run;
   logic              in_load;
   logic              read_issue;
   logic              load_start;
   logic              handshake;
   logic              load_end;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W-1:0] load_count;
   logic              load_full;
   logic              load_at_last;

   // Everything that can touch the port is qualified by rst so a held
   // reset blocks reads and writes even before the state register settles.
   assign in_run     = rst && (state_reg == RUN);
   assign in_load    = rst && (state_reg == LOAD);
   assign read_issue = in_run && fetch_en_i;
   assign load_start = in_run && ld_start_i;
   assign ld_ready_o = in_load && !load_full;
   assign handshake  = ld_ready_o && ld_valid_i;
   assign load_end   = handshake && (ld_last_i || load_at_last);

   imem_load_addr_gen #(
      .ADDR_W    (ADDR_W),
      .ADDR_STEP (ADDR_STEP)
   ) u_addr_gen (
      .clk     (clk),
      .rst     (rst),
      .clear   (load_start),
      .advance (handshake),
      .addr    (load_addr),
      .count   (load_count),
      .full    (load_full),
      .at_last (load_at_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg         <= FLUSH;
         flush_cnt_reg     <= FLUSH_INIT;
         fetch_pending_reg <= 1'b0;
      end else begin
         fetch_pending_reg <= read_issue;
         case (state_reg)
            FLUSH: begin
               if (flush_cnt_reg == '0) begin
                  state_reg <= RUN;
               end else begin
                  flush_cnt_reg <= flush_cnt_reg - FLUSH_W'(1);
               end
            end
            RUN: begin
               if (ld_start_i) begin
                  state_reg <= LOAD;
               end
            end
            LOAD: begin
               if (load_end) begin
                  state_reg     <= FLUSH;
                  flush_cnt_reg <= FLUSH_INIT;
               end
            end
            default: begin
               state_reg     <= FLUSH;
               flush_cnt_reg <= FLUSH_INIT;
            end
         endcase
      end
   end

   // Port mux: loader writes and fetch reads are mutually exclusive by state.
   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wren_o  = 1'b0;
      if (handshake) begin
         mem_addr_o  = load_addr;
         mem_wdata_o = ld_data_i;
         mem_wren_o  = 1'b1;
      end else if (read_issue) begin
         mem_addr_o = fetch_addr_i;
      end
   end

   assign cpu_hold_o    = !in_run;
   assign ld_busy_o     = in_load;
   assign ld_count_o    = load_count;
   assign fetch_valid_o = fetch_pending_reg;
   assign fetch_data_o  = fetch_pending_reg ? mem_q_i : '0;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: behavioural IMEM, table-driven fetch/load
// phases and queue scoreboards for returned fetch words and IMEM writes.
module tb_imem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_en;
   logic [8:0]  fetch_addr;
   logic [33:0] fetch_data;
   logic        fetch_valid;
   logic        cpu_hold;
   logic        ld_start;
   logic        ld_valid;
   logic [33:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        ld_busy;
   logic [8:0]  ld_count;
   logic [8:0]  mem_addr;
   logic [33:0] mem_wdata;
   logic        mem_wren;
   logic [33:0] mem_q;
   logic        mem_init;

   always #5 clk = ~clk;

   imem_port_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_en_i    (fetch_en),
      .fetch_addr_i  (fetch_addr),
      .fetch_data_o  (fetch_data),
      .fetch_valid_o (fetch_valid),
      .cpu_hold_o    (cpu_hold),
      .ld_start_i    (ld_start),
      .ld_valid_i    (ld_valid),
      .ld_data_i     (ld_data),
      .ld_last_i     (ld_last),
      .ld_ready_o    (ld_ready),
      .ld_busy_o     (ld_busy),
      .ld_count_o    (ld_count),
      .mem_addr_o    (mem_addr),
      .mem_wdata_o   (mem_wdata),
      .mem_wren_o    (mem_wren),
      .mem_q_i       (mem_q)
   );

   function automatic logic [33:0] pat(input int i);
      return {2'b10, 32'hC0DE_0000 | 32'(i)};
   endfunction

   // Behavioural IMEM: one-cycle synchronous read, read-before-write.
   logic [33:0] imem [0:127];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) imem[i] <= pat(i);
      end else if (mem_wren) begin
         imem[mem_addr[8:2]] <= mem_wdata;
      end
      mem_q <= imem[mem_addr[8:2]];
   end

   typedef struct {
      logic       en;
      logic [8:0] addr;
   } fetch_vec_t;

   typedef struct {
      logic        valid;
      logic [33:0] data;
      logic        last;
      logic [8:0]  exp_count;
   } load_vec_t;

   fetch_vec_t  fvec [6];
   load_vec_t   lvec [6];
   logic [33:0] shadow [0:127];
   logic [33:0] exp_fetch_q [$];
   logic [42:0] exp_wr_q [$];
   logic [8:0]  ld_addr_model;
   int          passed = 0;
   int          total  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic monitor();
      logic [42:0] w;
      if (fetch_valid) begin
         if (exp_fetch_q.size() == 0) chk("fetch_unexpected", fetch_valid, 0);
         else chk("fetch_data", fetch_data, exp_fetch_q.pop_front());
      end else begin
         chk("fetch_idle_zero", fetch_data, 0);
      end
      if (mem_wren) begin
         if (exp_wr_q.size() == 0) chk("wr_unexpected", mem_wren, 0);
         else begin
            w = exp_wr_q.pop_front();
            chk("wr_addr_data", {mem_addr, mem_wdata}, w);
         end
      end
   endtask

   // Inputs change at posedge+1; outputs are sampled on the falling edge.
   task automatic settle();
      #4;
      monitor();
      $display("t=%0t hold=%0b busy=%0b rdy=%0b wren=%0b addr=%03h cnt=%0d fv=%0b",
               $time, cpu_hold, ld_busy, ld_ready, mem_wren, mem_addr, ld_count, fetch_valid);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      adv();
   endtask

   task automatic push_word(input logic [33:0] d);
      exp_wr_q.push_back({ld_addr_model, d});
      shadow[ld_addr_model[8:2]] = d;
      ld_addr_model = ld_addr_model + 9'd4;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      settle();
      chk("start_busy_before", ld_busy, 0);
      adv();
      ld_start = 1'b0;
      ld_addr_model = '0;
   endtask

   task automatic flush_check(input int n, input logic [8:0] exp_count);
      for (int k = 0; k < n; k++) begin
         settle();
         chk("flush_hold", cpu_hold, 1);
         chk("flush_busy", ld_busy, 0);
         chk("flush_count", ld_count, exp_count);
         adv();
      end
      settle();
      chk("flush_to_run", cpu_hold, 0);
      adv();
   endtask

   initial begin
      rst = 1'b0; fetch_en = 1'b0; fetch_addr = '0; ld_start = 1'b0;
      ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; mem_init = 1'b1;
      ld_addr_model = '0;
      for (int i = 0; i < 128; i++) shadow[i] = pat(i);

      fvec[0] = '{1'b1, 9'h008};
      fvec[1] = '{1'b0, 9'h00C};
      fvec[2] = '{1'b1, 9'h010};
      fvec[3] = '{1'b1, 9'h1FC};
      fvec[4] = '{1'b0, 9'h000};
      fvec[5] = '{1'b1, 9'h004};

      lvec[0] = '{1'b0, 34'h0,          1'b0, 9'd0};
      lvec[1] = '{1'b1, 34'h2_AAAA_0001, 1'b0, 9'd0};
      lvec[2] = '{1'b0, 34'h0,          1'b1, 9'd1};
      lvec[3] = '{1'b1, 34'h1_BBBB_0002, 1'b0, 9'd1};
      lvec[4] = '{1'b0, 34'h0,          1'b0, 9'd2};
      lvec[5] = '{1'b1, 34'h3_CCCC_0003, 1'b1, 9'd2};

      // Reset held for two edges, then a 3-cycle flush window.
      adv();
      settle();
      chk("rst_hold", cpu_hold, 1);
      chk("rst_ready", ld_ready, 0);
      chk("rst_busy", ld_busy, 0);
      chk("rst_wren", mem_wren, 0);
      chk("rst_fetch_valid", fetch_valid, 0);
      chk("rst_count", ld_count, 0);
      adv();
      rst = 1'b1;
      mem_init = 1'b0;
      for (int k = 0; k < 3; k++) begin
         settle();
         chk("reset_flush_hold", cpu_hold, 1);
         chk("reset_flush_wren", mem_wren, 0);
         adv();
      end
      settle();
      chk("reset_run", cpu_hold, 0);
      adv();

      // Fetch reads in RUN.
      for (int i = 0; i < 6; i++) begin
         fetch_en = fvec[i].en;
         fetch_addr = fvec[i].addr;
         if (fvec[i].en) exp_fetch_q.push_back(shadow[fvec[i].addr[8:2]]);
         settle();
         chk("fetch_mem_addr", mem_addr, fvec[i].en ? fvec[i].addr : 9'h000);
         chk("fetch_hold", cpu_hold, 0);
         adv();
      end
      fetch_en = 1'b0;
      fetch_addr = '0;
      cyc();
      chk("fetch_drain", exp_fetch_q.size(), 0);

      // Three-word load with gaps; ld_last without a handshake is ignored.
      start_load();
      for (int i = 0; i < 6; i++) begin
         ld_valid = lvec[i].valid;
         ld_data = lvec[i].data;
         ld_last = lvec[i].last;
         if (lvec[i].valid) push_word(lvec[i].data);
         settle();
         chk("load_ready", ld_ready, 1);
         chk("load_busy", ld_busy, 1);
         chk("load_hold", cpu_hold, 1);
         chk("load_count", ld_count, lvec[i].exp_count);
         if (!lvec[i].valid) chk("load_idle_addr", mem_addr, 0);
         adv();
      end
      ld_valid = 1'b0;
      ld_last = 1'b0;
      flush_check(3, 9'd3);
      fetch_en = 1'b1;
      fetch_addr = 9'h004;
      exp_fetch_q.push_back(shadow[1]);
      cyc();
      fetch_en = 1'b0;
      cyc();

      // Fill the whole address space without ld_last.
      start_load();
      for (int i = 0; i < 128; i++) begin
         ld_valid = 1'b1;
         ld_data = {2'($urandom), $urandom};
         push_word(ld_data);
         settle();
         chk("full_ready", ld_ready, 1);
         adv();
      end
      settle();
      chk("full_ready_drop", ld_ready, 0);
      chk("full_count", ld_count, 9'd128);
      chk("full_busy", ld_busy, 0);
      chk("full_hold", cpu_hold, 1);
      adv();
      ld_valid = 1'b0;
      flush_check(2, 9'd128);

      // Reset in the middle of a load.
      start_load();
      for (int i = 0; i < 2; i++) begin
         ld_valid = 1'b1;
         ld_data = pat(200 + i);
         push_word(ld_data);
         cyc();
      end
      rst = 1'b0;
      ld_data = pat(300);
      settle();
      chk("rstmid_wren", mem_wren, 0);
      chk("rstmid_ready", ld_ready, 0);
      chk("rstmid_busy", ld_busy, 0);
      chk("rstmid_hold", cpu_hold, 1);
      adv();
      rst = 1'b1;
      settle();
      chk("rstmid_after_busy", ld_busy, 0);
      chk("rstmid_after_count", ld_count, 0);
      chk("rstmid_after_ready", ld_ready, 0);
      adv();
      ld_valid = 1'b0;
      flush_check(2, 9'd0);

      // Fetch and load start together; start during FLUSH is ignored.
      fetch_en = 1'b1;
      fetch_addr = 9'h010;
      ld_start = 1'b1;
      exp_fetch_q.push_back(shadow[4]);
      settle();
      chk("both_mem_addr", mem_addr, 9'h010);
      adv();
      fetch_en = 1'b0;
      ld_start = 1'b0;
      ld_addr_model = '0;
      settle();
      chk("both_busy", ld_busy, 1);
      chk("both_count", ld_count, 0);
      chk("both_fetch_valid", fetch_valid, 1);
      adv();
      ld_valid = 1'b1;
      ld_last = 1'b1;
      ld_data = 34'h0_DDDD_0004;
      push_word(ld_data);
      cyc();
      ld_valid = 1'b0;
      ld_last = 1'b0;
      ld_start = 1'b1;
      settle();
      chk("flush_start_busy", ld_busy, 0);
      adv();
      ld_start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         settle();
         chk("flush_start_ignored", ld_busy, 0);
         chk("flush_start_hold", cpu_hold, 1);
         adv();
      end
      settle();
      chk("flush_start_run_busy", ld_busy, 0);
      chk("flush_start_run_hold", cpu_hold, 0);
      adv();
      cyc();

      chk("fetch_q_empty", exp_fetch_q.size(), 0);
      chk("wr_q_empty", exp_wr_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
